// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: word loads/stores, byte/half loads with extension,
// and byte/half stores performed as read-modify-write on a word-only memory.
module dm_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        exc,
    output logic [31:0] rdata,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_Wr,
    input  logic [31:0] mem_DR
);

    // state  | meaning
    // IDLE   | waiting for req; ACCESS | read or word write; WRITE | RMW word write
    // DONE   | completion pulse; ERR | misaligned/reserved access pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      next;

    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    logic        misaligned;
    logic        sub_store;
    logic [31:0] word_addr;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    assign misaligned = (size == 2'd3)
                      | ((size == 2'd2) & (addr[1:0] != 2'b00))
                      | ((size == 2'd1) & addr[0]);

    assign sub_store = we_q & (size_q != 2'd2);
    assign word_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        byte_lane = mem_DR[7:0];
        case (addr_q[1:0])
            2'd0: byte_lane = mem_DR[7:0];
            2'd1: byte_lane = mem_DR[15:8];
            2'd2: byte_lane = mem_DR[23:16];
            2'd3: byte_lane = mem_DR[31:24];
            default: byte_lane = mem_DR[7:0];
        endcase
        half_lane = addr_q[1] ? mem_DR[31:16] : mem_DR[15:0];
    end

    always_comb begin
        load_val = mem_DR;
        case (size_q)
            2'd0: load_val = {{24{sext_q & byte_lane[7]}}, byte_lane};
            2'd1: load_val = {{16{sext_q & half_lane[15]}}, half_lane};
            default: load_val = mem_DR;
        endcase
    end

    // Replace only the addressed lane; the rest of the word comes from memory.
    always_comb begin
        merge_val = mem_DR;
        if (size_q == 2'd0) begin
            case (addr_q[1:0])
                2'd0: merge_val[7:0]   = wdata_q[7:0];
                2'd1: merge_val[15:8]  = wdata_q[7:0];
                2'd2: merge_val[23:16] = wdata_q[7:0];
                2'd3: merge_val[31:24] = wdata_q[7:0];
                default: merge_val = mem_DR;
            endcase
        end else if (addr_q[1]) begin
            merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sext_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            merge_q <= 32'd0;
            rdata   <= 32'd0;
        end else begin
            if (state == S_IDLE && req) begin
                we_q    <= we;
                size_q  <= size;
                sext_q  <= sext;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == S_ACCESS) begin
                if (!we_q) begin
                    rdata <= load_val;
                end else if (sub_store) begin
                    merge_q <= merge_val;
                end
            end
        end
    end

    // Outputs decode from state only, so reset clears them without waiting for an edge.
    always_comb begin
        next   = state;
        busy   = (state != S_IDLE);
        done   = 1'b0;
        exc    = 1'b0;
        mem_A  = 32'd0;
        mem_WD = 32'd0;
        mem_Wr = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    next = misaligned ? S_ERR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_A = word_addr;
                if (sub_store) begin
                    next = S_WRITE;
                end else begin
                    next = S_DONE;
                    if (we_q) begin
                        mem_Wr = 1'b1;
                        mem_WD = wdata_q;
                    end
                end
            end
            S_WRITE: begin
                mem_A  = word_addr;
                mem_Wr = 1'b1;
                mem_WD = merge_q;
                next   = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                next = S_IDLE;
            end
            S_ERR: begin
                exc  = 1'b1;
                next = S_IDLE;
            end
            default: begin
                next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios plus random accesses
// compared against a byte-level memory/load reference model.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        exc;
    logic [31:0] rdata;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_Wr;
    logic [31:0] mem_DR;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        mem_clear;
    int          wr_count = 0;
    logic [31:0] exp_rdata;
    logic [31:0] last_wd;
    int          last_busy;

    dm_access_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .exc(exc),
        .rdata(rdata), .mem_A(mem_A), .mem_WD(mem_WD), .mem_Wr(mem_Wr),
        .mem_DR(mem_DR)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h01010101) ^ 32'hA5C30F1E;
    endfunction

    assign mem_DR = mem[mem_A[7:2]];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_Wr) begin
            mem[mem_A[7:2]] <= mem_WD;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access, checked cycle by cycle against the reference rules.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] d, input string tag);
        int          nb;
        int          off;
        int          idx;
        logic        mis;
        int          exp_busy;
        int          exp_wr_at;
        logic [31:0] word;
        logic [31:0] merged;
        logic [31:0] v;
        logic [31:0] mask;
        int          cyc;
        int          done_n;
        int          done_at;
        int          exc_n;
        int          wr_n;
        int          wr_at;
        logic [31:0] wr_a;
        logic [31:0] wr_d;
        logic        leak;
        logic [31:0] done_a;

        nb  = 1 << sz;
        off = a % 4;
        idx = (a % 256) / 4;
        mis = (sz == 2'd3) || ((a % nb) != 0);
        word = ref_mem[idx];
        merged = word;
        for (int i = 0; i < 4; i++) begin
            if (i < nb && !mis) merged[8*(off+i) +: 8] = d[8*i +: 8];
        end
        v = word >> (8 * off);
        if (nb < 4) begin
            mask = (32'd1 << (8 * nb)) - 32'd1;
            v = v & mask;
            if (sx && v[8*nb-1]) v = v | ~mask;
        end
        exp_busy  = mis ? 1 : ((w && nb < 4) ? 3 : 2);
        exp_wr_at = (mis || !w) ? 0 : ((nb < 4) ? 2 : 1);

        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; addr = $urandom; wdata = $urandom;

        cyc = 0; done_n = 0; done_at = 0; exc_n = 0; wr_n = 0; wr_at = 0;
        wr_a = 0; wr_d = 0; leak = 1'b0; done_a = 0;
        while (busy && cyc < 10) begin
            cyc++;
            if (done) begin done_n++; done_at = cyc; done_a = mem_A; end
            if (exc) exc_n++;
            if (mem_Wr) begin
                wr_n++; wr_at = cyc; wr_a = mem_A; wr_d = mem_WD;
            end else if (mem_WD !== 32'd0) begin
                leak = 1'b1;
            end
            @(posedge clk); #1;
        end

        if (!mis) begin
            if (w) ref_mem[idx] = merged;
            else   exp_rdata = v;
        end
        last_wd   = wr_d;
        last_busy = cyc;

        check({tag, " busy_cycles"}, cyc, exp_busy);
        check({tag, " done_count"}, done_n, mis ? 0 : 1);
        check({tag, " done_cycle"}, done_at, mis ? 0 : exp_busy);
        check({tag, " done_memA"}, done_a, 32'd0);
        check({tag, " exc_count"}, exc_n, mis ? 1 : 0);
        check({tag, " write_count"}, wr_n, (mis || !w) ? 0 : 1);
        check({tag, " write_cycle"}, wr_at, exp_wr_at);
        check({tag, " wd_when_idle"}, leak, 1'b0);
        if (wr_n == 1) begin
            check({tag, " write_addr"}, wr_a, {a[31:2], 2'b00});
            check({tag, " write_data"}, wr_d, ref_mem[idx]);
        end
        check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " mem_word"}, mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int          dn;
        int          wc;
        logic [1:0]  rs;
        logic [31:0] ra;

        rst = 1'b1; mem_clear = 1'b1;
        req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; addr = 32'd0; wdata = 32'd0;
        exp_rdata = 32'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset exc", exc, 1'b0);
        check("reset mem_Wr", mem_Wr, 1'b0);
        check("reset mem_A", mem_A, 32'd0);
        check("reset mem_WD", mem_WD, 32'd0);
        check("reset rdata", rdata, 32'd0);
        rst = 1'b0; mem_clear = 1'b0;
        @(posedge clk); #1;

        do_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw_10");
        do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw_10");
        check("lw_10 value", rdata, 32'hDEADBEEF);

        do_access(1'b1, 2'd2, 1'b0, 32'h20, 32'h12AB34CD, "sw_20");
        do_access(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, "lb_22");
        check("lb_22 value", rdata, 32'hFFFFFFAB);
        do_access(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, "lbu_22");
        check("lbu_22 value", rdata, 32'h000000AB);
        do_access(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "lh_22");
        check("lh_22 value", rdata, 32'h000012AB);

        do_access(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, "sw_30");
        do_access(1'b1, 2'd0, 1'b0, 32'h31, 32'h000000EE, "sb_31");
        check("sb_31 write_data", last_wd, 32'h1122EE44);
        check("sb_31 busy", last_busy, 3);
        check("sb_31 mem", mem[12], 32'h1122EE44);

        do_access(1'b1, 2'd1, 1'b0, 32'h41, 32'h0000BEEF, "sh_41_mis");
        do_access(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, "lw_42_mis");
        check("lw_42 rdata kept", rdata, 32'h1122EE44 ^ 32'h1122EE44 ^ exp_rdata);
        do_access(1'b0, 2'd3, 1'b0, 32'h44, 32'h0, "size3");
        do_access(1'b1, 2'd3, 1'b0, 32'h48, 32'h12345678, "size3_st");

        // Reset while a byte store sits in ACCESS.
        wc = wr_count;
        req = 1'b1; we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'h51; wdata = 32'h000000AA;
        @(posedge clk); #1;
        req = 1'b0;
        check("rmw_rst in_access", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rmw_rst busy", busy, 1'b0);
        check("rmw_rst done", done, 1'b0);
        check("rmw_rst exc", exc, 1'b0);
        check("rmw_rst mem_Wr", mem_Wr, 1'b0);
        check("rmw_rst mem_A", mem_A, 32'd0);
        check("rmw_rst mem_WD", mem_WD, 32'd0);
        check("rmw_rst rdata", rdata, 32'd0);
        exp_rdata = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rmw_rst no_write", wr_count, wc);
        check("rmw_rst word", mem[20], ref_mem[20]);
        do_access(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, "lw_after_rst");

        // req held high: only IDLE-sampled requests are taken.
        dn = 0;
        for (int i = 0; i < 9; i++) begin
            req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h20 + 4 * i;
            @(posedge clk); #1;
            if (done) dn++;
        end
        req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        exp_rdata = ref_mem[32'h38 / 4];
        check("hold_req accepts", dn, 3);
        check("hold_req rdata", rdata, exp_rdata);

        for (int n = 0; n < 200; n++) begin
            rs = 2'($urandom_range(0, 3));
            ra = $urandom;
            if (rs != 2'd3 && ($urandom % 3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
            do_access(1'($urandom % 2), rs, 1'($urandom % 2), ra, $urandom, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Pipeline-side memory access controller that drives the word-wide data memory port (word address, write data, write enable, combinational read data). It accepts one load or store per request from the MEM stage and converts byte and halfword stores into a read-modify-write sequence, since the memory only writes whole words. It also performs load byte-lane extraction with sign or zero extension, and flags misaligned accesses.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned)
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data; right-justified for byte/half
- busy  out  1  high whenever state != IDLE; pipeline stalls on it
- done  out  1  one-cycle pulse when an access completes
- exc  out  1  one-cycle pulse on a misaligned or reserved access
- rdata  out  32  registered load result; held until the next load completes
- mem_A  out  32  to memory address: {addr_q[31:2],2'b00} in ACCESS/WRITE, else 0
- mem_WD  out  32  to memory write data; 0 when mem_Wr is low
- mem_Wr  out  1  to memory write enable; decoded combinationally from state
- mem_DR  in  32  from memory read data; combinational in mem_A

## Operation
- States: IDLE, ACCESS, WRITE, DONE, ERR.
- IDLE with req=1: latch we, size, sext, addr, wdata into *_q registers.
  - Aligned access: go to ACCESS.
  - Misaligned access: go to ERR.
- Alignment rules:
  - word requires addr[1:0]=0.
  - half requires addr[0]=0.
  - byte is always aligned.
  - size=3 is always an error.
- ACCESS:
  - Word store: mem_Wr=1, mem_WD=wdata_q; next state DONE.
  - Load: rdata <= extend(lane(mem_DR)); next state DONE.
  - Byte/half store: merge_q <= mem_DR with the target lane replaced by wdata_q[7:0] or wdata_q[15:0]; next state WRITE.
- WRITE: mem_Wr=1, mem_WD=merge_q; next state DONE.
- DONE: done=1; next state IDLE.
- ERR: exc=1; no memory write, rdata unchanged; next state IDLE.
- Lanes are little-endian:
  - Byte k = addr_q[1:0] occupies bits [8k+7:8k].
  - Half h = addr_q[1] occupies bits [16h+15:16h].
- Extension: sext=1 replicates the lane MSB into the upper bits; sext=0 fills the upper bits with zeros. Word loads pass through unchanged.
- req while busy=1 is ignored; it is not queued.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE.
  - busy, done, exc, mem_Wr = 0.
  - mem_A, mem_WD, rdata, merge_q = 0.
- Request sampled at edge E0 (IDLE, req=1); ACCESS occupies the cycle after E0.
- Load and word store: ACCESS, DONE; done is high 2 cycles after the req cycle; total busy = 2 cycles.
- Byte/half store: ACCESS, WRITE, DONE; busy = 3 cycles; memory write commits at the edge ending WRITE.
- Misaligned access: ERR for 1 cycle; exc high in the cycle after the req cycle; busy = 1 cycle.
- A new req may be presented in the DONE or ERR cycle but is not accepted until IDLE, i.e. next back-to-back accept is 1 cycle after DONE.
- Reset during ACCESS or WRITE: mem_Wr falls with the reset assertion. A write is never committed at a later edge. An RMW interrupted before WRITE leaves memory unmodified.
- mem_DR is consumed only in ACCESS; its value in other states is don't-care.

## Test plan
- Word store then load:
  - Store 0xDEADBEEF at addr 0x10 -> mem_Wr for exactly 1 cycle with mem_A=0x10.
  - Load addr 0x10 -> rdata=0xDEADBEEF; done 2 cycles after each req.
- Byte load with extension, memory word at 0x20 = 0x12AB34CD:
  - Load byte, addr 0x22, sext=1 -> rdata=0xFFFFFFAB.
  - Load byte, addr 0x22, sext=0 -> rdata=0x000000AB.
  - Load half, addr 0x22, sext=1 -> rdata=0x000012AB.
- Byte store RMW, word at 0x30 = 0x11223344:
  - Store byte 0xEE at addr 0x31 -> exactly one write, mem_WD=0x1122EE44, in the WRITE cycle; busy for 3 cycles.
- Misalignment:
  - Half store at 0x41 -> exc pulse, no mem_Wr, done stays 0.
  - Word load at 0x42 -> exc pulse, rdata unchanged.
  - size=3 -> exc pulse.
- Reset mid-RMW:
  - Assert rst during ACCESS of a byte store -> mem_Wr never asserts, word unchanged, all outputs 0 immediately.
  - After release, a fresh load completes normally.
- Busy blocking:
  - Hold req high continuously with changing addr -> only requests sampled in IDLE are accepted, one access per 3 cycles for loads.
